conv_ofmap_streamer: RTL and testbench

Output-side companion to `conv`. When `conv` signals `conv_done`, this block walks the parallel `conv_ofmap` array in row-major order. It emits one pixel per beat on a valid/ready stream, with row-end and frame-end markers. This replaces bench-side whole-array dumps and feeds downstream serial consumers such as a DMA writer or pooling input.

---
 rtl/conv_ofmap_streamer.sv | 122 ++++++++++++
 tb/tb_conv_ofmap_streamer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_ofmap_streamer.sv
// Streams a square output feature map in row-major order on a valid/ready port.
// A rising edge on start launches one frame; row-end and frame-end markers ride with each beat.
module conv_ofmap_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int OFMAP_SIZE = 126
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] conv_ofmap [0:OFMAP_SIZE-1][0:OFMAP_SIZE-1],
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_row_last,
   output logic                  m_frame_last,
   output logic                  busy,
   output logic                  stream_done
);

   // state  | meaning
   // IDLE   | waiting for a start edge, no beat offered
   // STREAM | offering pixel [row][col], advancing on each handshake
   // DONE   | single-cycle stream_done pulse, then back to IDLE

   localparam int CW = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1;
   localparam logic [CW-1:0] LAST = CW'(OFMAP_SIZE - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t                state, state_d;
   logic [CW-1:0]         row, col, row_d, col_d, row_nx, col_nx;
   logic                  start_q, start_edge, hs;
   logic [DATA_WIDTH-1:0] m_data_d;
   logic                  m_valid_d, m_row_last_d, m_frame_last_d, busy_d, stream_done_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         row          <= '0;
         col          <= '0;
         start_q      <= 1'b0;
         m_data       <= '0;
         m_valid      <= 1'b0;
         m_row_last   <= 1'b0;
         m_frame_last <= 1'b0;
         busy         <= 1'b0;
         stream_done  <= 1'b0;
      end else begin
         state        <= state_d;
         row          <= row_d;
         col          <= col_d;
         start_q      <= start;
         m_data       <= m_data_d;
         m_valid      <= m_valid_d;
         m_row_last   <= m_row_last_d;
         m_frame_last <= m_frame_last_d;
         busy         <= busy_d;
         stream_done  <= stream_done_d;
      end
   end

   always_comb begin
      start_edge     = start & ~start_q;
      hs             = m_valid & m_ready;
      state_d        = state;
      row_d          = row;
      col_d          = col;
      m_data_d       = m_data;
      m_valid_d      = m_valid;
      m_row_last_d   = m_row_last;
      m_frame_last_d = m_frame_last;
      busy_d         = busy;
      stream_done_d  = 1'b0;

      // Row-major successor of the current index; only used on non-final beats.
      if (col == LAST) begin
         col_nx = '0;
         row_nx = row + CW'(1);
      end else begin
         col_nx = col + CW'(1);
         row_nx = row;
      end

      case (state)
         IDLE: begin
            if (start_edge) begin
               row_d          = '0;
               col_d          = '0;
               m_data_d       = conv_ofmap[0][0];
               m_valid_d      = 1'b1;
               busy_d         = 1'b1;
               m_row_last_d   = (LAST == '0);
               m_frame_last_d = (LAST == '0);
               state_d        = STREAM;
            end
         end
         STREAM: begin
            if (hs) begin
               if (m_frame_last) begin
                  m_valid_d     = 1'b0;
                  busy_d        = 1'b0;
                  stream_done_d = 1'b1;
                  state_d       = DONE;
               end else begin
                  row_d          = row_nx;
                  col_d          = col_nx;
                  m_data_d       = conv_ofmap[row_nx][col_nx];
                  m_row_last_d   = (col_nx == LAST);
                  m_frame_last_d = (row_nx == LAST) && (col_nx == LAST);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_conv_ofmap_streamer.sv
// Directed bench for conv_ofmap_streamer on a 4x4 map (values 4r+c) plus a 1x1 instance.
// Frames are checked beat by beat against an index counter; multi-cycle corners use a vector table.
module tb_conv_ofmap_streamer;

   logic       clk = 1'b0;
   logic       reset, start, m_ready;
   logic [7:0] map [0:3][0:3];
   logic       m_valid, m_row_last, m_frame_last, busy, stream_done;
   logic [7:0] m_data;

   logic       one_start, one_ready;
   logic [7:0] one_map [0:0][0:0];
   logic       one_valid, one_row_last, one_frame_last, one_busy, one_done;
   logic [7:0] one_data;

   int n_pass = 0;
   int n_total = 0;
   int beats;

   always #5 clk = ~clk;

   conv_ofmap_streamer #(.DATA_WIDTH(8), .OFMAP_SIZE(4)) u_dut (
      .clk(clk), .reset(reset), .start(start), .conv_ofmap(map),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_row_last(m_row_last), .m_frame_last(m_frame_last),
      .busy(busy), .stream_done(stream_done)
   );

   conv_ofmap_streamer #(.DATA_WIDTH(8), .OFMAP_SIZE(1)) u_one (
      .clk(clk), .reset(reset), .start(one_start), .conv_ofmap(one_map),
      .m_valid(one_valid), .m_ready(one_ready), .m_data(one_data),
      .m_row_last(one_row_last), .m_frame_last(one_frame_last),
      .busy(one_busy), .stream_done(one_done)
   );

   typedef struct {
      logic       rst;
      logic       st;
      logic       rdy;
      logic       v;
      logic [7:0] d;
      logic       rl;
      logic       fl;
      logic       bz;
      logic       dn;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [12:0] outs();
      return {m_valid, m_data, m_row_last, m_frame_last, busy, stream_done};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered with beat 0 on the port; returns one cycle after the final handshake.
   task automatic collect_frame(input string tag, input bit bp, output int nbeats);
      int         idx = 0;
      logic       pv = 1'b0, pr = 1'b0, lastbeat = 1'b0;
      logic [10:0] pout = '0;
      bit         fin = 1'b0;
      nbeats = 0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         chk({tag, " valid"}, m_valid, 1);
         if (pv && !pr)
            chk({tag, " stall"}, {m_data, m_row_last, m_frame_last, busy}, pout);
         if (bp) m_ready = (cyc < 4) ? (cyc == 0 || cyc == 3) : 1'($urandom_range(0, 1));
         else    m_ready = 1'b1;
         lastbeat = 1'b0;
         if (m_valid && m_ready) begin
            chk({tag, " beat"}, {m_data, m_row_last, m_frame_last, busy},
                {idx[7:0], (idx % 4) == 3, idx == 15, 1'b1});
            lastbeat = m_frame_last;
            idx++;
            nbeats++;
         end
         pv   = m_valid;
         pr   = m_ready;
         pout = {m_data, m_row_last, m_frame_last, busy};
         step();
         if (lastbeat) fin = 1'b1;
      end
      if (!fin) chk({tag, " timeout"}, 0, 1);
      chk({tag, " done pulse"}, {m_valid, busy, stream_done}, 3'b001);
      m_ready = 1'b1;
   endtask

   initial begin
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            map[r][c] = 8'(4 * r + c);
      one_map[0][0] = 8'hA5;
      one_start = 1'b0;
      one_ready = 1'b0;

      //          rst   st    rdy   v     d      rl    fl    bz    dn
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd8, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};

      // Reset with start and ready already high; release counts as a start edge.
      reset = 1'b1;
      start = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset outs", outs(), 13'h0);
      end
      reset = 1'b0;
      step();
      chk("first beat after reset", outs(), {1'b1, 8'd0, 4'b0010});
      collect_frame("frame_a", 1'b0, beats);
      chk("frame_a beats", beats, 16);
      step();
      chk("frame_a idle", outs() & 13'h1003, 13'h0);

      // Level start held high: no retrigger.
      for (int i = 0; i < 8; i++) begin
         step();
         chk("level hold", {m_valid, busy, stream_done}, 3'b000);
      end
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      chk("fresh edge", outs(), {1'b1, 8'd0, 4'b0010});
      collect_frame("frame_bp", 1'b1, beats);
      chk("frame_bp beats", beats, 16);
      start = 1'b0;
      step();
      chk("frame_bp idle", {m_valid, busy, stream_done}, 3'b000);

      // Start edge landing in DONE is dropped; next edge is accepted.
      start = 1'b1;
      step();
      start = 1'b0;
      chk("pulse start", outs(), {1'b1, 8'd0, 4'b0010});
      collect_frame("frame_c", 1'b0, beats);
      start = 1'b1;
      step();
      chk("edge in done", {m_valid, busy, stream_done}, 3'b000);
      step();
      chk("no retrigger", {m_valid, busy, stream_done}, 3'b000);
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      chk("edge at ef+2 era", outs(), {1'b1, 8'd0, 4'b0010});
      collect_frame("frame_d", 1'b0, beats);
      chk("frame_d beats", beats, 16);
      start = 1'b0;
      step();
      step();

      // Start during busy, a stall, then mid-stream reset.
      for (int i = 0; i < 15; i++) begin
         reset   = tbl[i].rst;
         start   = tbl[i].st;
         m_ready = tbl[i].rdy;
         step();
         chk($sformatf("table row %0d", i), outs(),
             {tbl[i].v, tbl[i].d, tbl[i].rl, tbl[i].fl, tbl[i].bz, tbl[i].dn});
      end
      start = 1'b0;
      collect_frame("frame_e", 1'b0, beats);
      chk("frame_e beats", beats, 16);
      step();

      // Single-pixel map: first beat is both row and frame last.
      one_start = 1'b1;
      step();
      chk("one first", {one_valid, one_data, one_row_last, one_frame_last, one_busy, one_done},
          {1'b1, 8'hA5, 4'b1110});
      step();
      chk("one stall", {one_valid, one_data, one_row_last, one_frame_last, one_busy, one_done},
          {1'b1, 8'hA5, 4'b1110});
      one_ready = 1'b1;
      step();
      chk("one done", {one_valid, one_busy, one_done}, 3'b001);
      step();
      chk("one idle", {one_valid, one_busy, one_done}, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
